pistormx_op_sched: RTL and testbench

- Sequences Pi-originated bus operations into the 68K bus-cycle engine.
- Sits between the Pi register interface and the S0–S7 bus state machine.
- Holds posted writes in a small FIFO so the Pi need not wait for each write's DTACK/VPA completion.
- Enforces ordering: a read never overtakes a buffered write. Returns read data and busy status to the Pi side.

---
 rtl/pistormx_pkg.sv | 25 ++
 rtl/pistormx_wbuf_fifo.sv | 46 ++++
 rtl/pistormx_op_sched.sv | 175 +++++++++++++++++
 tb/tb_pistormx_op_sched.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pistormx_pkg.sv
// Shared definitions for the PiStorm-X bus-operation scheduler.
package pistormx_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;

   typedef enum logic [1:0] {
      StIdle  = ST_IDLE,
      StIssue = ST_ISSUE,
      StWait  = ST_WAIT
   } op_state_e;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   // {addr[22:0], a0, sz, wdata[15:0]} for the default 23-bit address
   localparam int unsigned OP_ENTRY_W = 41;

   localparam logic [2:0] REG_DATA    = 3'd0;
   localparam logic [2:0] REG_ADDR_LO = 3'd1;
   localparam logic [2:0] REG_ADDR_HI = 3'd2;
   localparam logic [2:0] REG_STATUS  = 3'd3;

endpackage

// File: rtl/pistormx_wbuf_fifo.sv
// Posted-write FIFO: synchronous, power-of-two depth, extra pointer MSB tells full from empty.
module pistormx_wbuf_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 41
) (
   input  logic                   c7m,
   input  logic                   reset,
   input  logic                   push,
   input  logic [WIDTH-1:0]       wdata,
   input  logic                   pop,
   output logic [WIDTH-1:0]       rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);

   localparam int unsigned IW = $clog2(DEPTH);

   logic [IW:0]      wr_ptr_q, rd_ptr_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[IW] != rd_ptr_q[IW]) && (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);
   assign level = wr_ptr_q - rd_ptr_q;
   assign rdata = mem_q[rd_ptr_q[IW-1:0]];

   // A pop frees the head slot this cycle, so a full FIFO may take a push alongside it.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge c7m) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge c7m) begin
      if (do_push) mem_q[wr_ptr_q[IW-1:0]] <= wdata;
   end

endmodule

// File: rtl/pistormx_op_sched.sv
// Sequences Pi bus operations into the 68K bus engine, reads never overtaking queued writes.
// Define PISTORMX_WBUF_EN for the posted-write FIFO; otherwise one operation is in flight at a time.
module pistormx_op_sched
   import pistormx_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 23
) (
   input  logic                   c7m,
   input  logic                   reset,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_rw,
   input  logic                   req_sz,
   input  logic                   req_a0,
   input  logic [AW-1:0]          req_addr,
   input  logic [15:0]            req_wdata,
   input  logic                   eng_idle,
   output logic                   eng_start,
   output logic                   eng_rw,
   output logic                   eng_sz,
   output logic                   eng_a0,
   output logic [AW-1:0]          eng_addr,
   output logic [15:0]            eng_wdata,
   input  logic                   eng_done,
   input  logic [15:0]            eng_rdata,
   output logic [15:0]            rd_data,
   output logic                   rd_valid,
   output logic                   txn_in_progress,
   output logic [$clog2(DEPTH):0] wbuf_level
);

   op_state_e     state_q;
   logic          pend_q, pend_sz_q, pend_a0_q;
   logic [AW-1:0] pend_addr_q;
   logic          accept, done, launch, pend_set, pend_clr;
   logic          src_rw, src_sz, src_a0;
   logic [AW-1:0] src_addr;
   logic [15:0]   src_wdata;

   assign accept = req_valid && req_ready;
   assign done   = (state_q == StWait) && eng_done;

`ifdef PISTORMX_WBUF_EN
   localparam int unsigned EntryW = AW + 18;

   logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [EntryW-1:0] fifo_head;
   logic [AW-1:0]     head_addr;
   logic              head_a0, head_sz;
   logic [15:0]       head_wdata;

   assign fifo_push = accept && (req_rw == RW_WRITE);
   assign fifo_pop  = done && (eng_rw == RW_WRITE);
   assign {head_addr, head_a0, head_sz, head_wdata} = fifo_head;

   pistormx_wbuf_fifo #(
      .DEPTH(DEPTH),
      .WIDTH(EntryW)
   ) u_wbuf (
      .c7m  (c7m),
      .reset(reset),
      .push (fifo_push),
      .wdata({req_addr, req_a0, req_sz, req_wdata}),
      .pop  (fifo_pop),
      .rdata(fifo_head),
      .full (fifo_full),
      .empty(fifo_empty),
      .level(wbuf_level)
   );

   // An outstanding read stalls all requests so later writes cannot slip ahead of it.
   assign req_ready = !reset && !pend_q && ((req_rw == RW_READ) || !fifo_full);
   assign pend_set  = accept && (req_rw == RW_READ);
   assign pend_clr  = done && (eng_rw == RW_READ);
   assign launch    = eng_idle && (!fifo_empty || pend_q);

   // Queued writes drain before the pending read is allowed out.
   always_comb begin
      src_rw    = RW_WRITE;
      src_sz    = head_sz;
      src_a0    = head_a0;
      src_addr  = head_addr;
      src_wdata = head_wdata;
      if (fifo_empty) begin
         src_rw   = RW_READ;
         src_sz   = pend_sz_q;
         src_a0   = pend_a0_q;
         src_addr = pend_addr_q;
      end
   end
`else
   logic        pend_rw_q;
   logic [15:0] pend_wdata_q;

   assign wbuf_level = '0;
   assign req_ready  = !reset && !pend_q;
   assign pend_set   = accept;
   assign pend_clr   = done;
   assign launch     = eng_idle && pend_q;
   assign src_rw     = pend_rw_q;
   assign src_sz     = pend_sz_q;
   assign src_a0     = pend_a0_q;
   assign src_addr   = pend_addr_q;
   assign src_wdata  = pend_wdata_q;

   always_ff @(posedge c7m) begin
      if (reset) begin
         pend_rw_q    <= RW_READ;
         pend_wdata_q <= '0;
      end else if (pend_set) begin
         pend_rw_q    <= req_rw;
         pend_wdata_q <= req_wdata;
      end
   end
`endif

   assign txn_in_progress = (wbuf_level != '0) || pend_q || (state_q != StIdle);

   always_ff @(posedge c7m) begin
      if (reset) begin
         state_q     <= StIdle;
         eng_start   <= 1'b0;
         eng_rw      <= RW_READ;
         eng_sz      <= 1'b0;
         eng_a0      <= 1'b0;
         eng_addr    <= '0;
         eng_wdata   <= '0;
         rd_data     <= '0;
         rd_valid    <= 1'b0;
         pend_q      <= 1'b0;
         pend_sz_q   <= 1'b0;
         pend_a0_q   <= 1'b0;
         pend_addr_q <= '0;
      end else begin
         eng_start <= 1'b0;
         case (state_q)
            StIdle: begin
               if (launch) begin
                  state_q   <= StIssue;
                  eng_start <= 1'b1;
                  eng_rw    <= src_rw;
                  eng_sz    <= src_sz;
                  eng_a0    <= src_a0;
                  eng_addr  <= src_addr;
                  eng_wdata <= src_wdata;
               end
            end
            StIssue: state_q <= StWait;
            StWait: begin
               if (eng_done) begin
                  state_q <= StIdle;
                  if (eng_rw == RW_READ) begin
                     rd_data  <= eng_rdata;
                     rd_valid <= 1'b1;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase

         if (accept) rd_valid <= 1'b0;

         if (pend_set) begin
            pend_q      <= 1'b1;
            pend_sz_q   <= req_sz;
            pend_a0_q   <= req_a0;
            pend_addr_q <= req_addr;
         end else if (pend_clr) begin
            pend_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pistormx_op_sched.sv
// Randomised bench for pistormx_op_sched against a transaction-level model; also exercises the FIFO.
module tb_pistormx_op_sched;

   localparam int unsigned DEPTH  = 4;
   localparam int unsigned AW     = 23;
   localparam int unsigned NCYC   = 3000;
   localparam logic        RD     = 1'b1;
   localparam logic        WR     = 1'b0;
`ifdef PISTORMX_WBUF_EN
   localparam bit WbufEn = 1'b1;
`else
   localparam bit WbufEn = 1'b0;
`endif

   logic c7m = 1'b0;
   always #5 c7m = ~c7m;

   logic          rst;
   logic          req_valid, req_ready, req_rw, req_sz, req_a0;
   logic [AW-1:0] req_addr;
   logic [15:0]   req_wdata;
   logic          eng_idle, eng_start, eng_rw, eng_sz, eng_a0, eng_done;
   logic [AW-1:0] eng_addr;
   logic [15:0]   eng_wdata, eng_rdata, rd_data;
   logic          rd_valid, txn_in_progress;
   logic [2:0]    wbuf_level;

   pistormx_op_sched #(
      .DEPTH(DEPTH),
      .AW   (AW)
   ) dut (
      .c7m            (c7m),
      .reset          (rst),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_rw         (req_rw),
      .req_sz         (req_sz),
      .req_a0         (req_a0),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .eng_idle       (eng_idle),
      .eng_start      (eng_start),
      .eng_rw         (eng_rw),
      .eng_sz         (eng_sz),
      .eng_a0         (eng_a0),
      .eng_addr       (eng_addr),
      .eng_wdata      (eng_wdata),
      .eng_done       (eng_done),
      .eng_rdata      (eng_rdata),
      .rd_data        (rd_data),
      .rd_valid       (rd_valid),
      .txn_in_progress(txn_in_progress),
      .wbuf_level     (wbuf_level)
   );

   // Stand-alone FIFO instance so its behaviour is covered in every build.
   logic        f_push, f_pop, f_full, f_empty;
   logic [40:0] f_wdata, f_rdata;
   logic [2:0]  f_level;

   pistormx_wbuf_fifo #(
      .DEPTH(DEPTH),
      .WIDTH(41)
   ) u_fifo (
      .c7m  (c7m),
      .reset(rst),
      .push (f_push),
      .wdata(f_wdata),
      .pop  (f_pop),
      .rdata(f_rdata),
      .full (f_full),
      .empty(f_empty),
      .level(f_level)
   );

   typedef struct packed {
      logic          rw;
      logic          sz;
      logic          a0;
      logic [AW-1:0] addr;
      logic [15:0]   wdata;
   } op_t;

   localparam op_t RstOp = '{rw: 1'b1, sz: 1'b0, a0: 1'b0, addr: '0, wdata: '0};

   // Model: queued writes, one pending op, and the op currently on the bus.
   op_t         wq[$];
   op_t         pend_op, cur_op, last_op;
   bit          m_pend, start_due, outstanding, m_rdv;
   logic [15:0] m_rdd;
   logic [40:0] fq[$];
   int          eng_cnt;
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      wq.delete();
      fq.delete();
      m_pend      = 1'b0;
      start_due   = 1'b0;
      outstanding = 1'b0;
      m_rdv       = 1'b0;
      m_rdd       = '0;
      last_op     = RstOp;
      pend_op     = RstOp;
      cur_op      = RstOp;
      eng_cnt     = 0;
   endtask

   task automatic drive_cycle(input int cyc);
      int p_req, p_rd, p_idle;
      case ((cyc / 250) % 4)
         0:       begin p_req = 50;  p_rd = 30; p_idle = 90;  end
         1:       begin p_req = 100; p_rd = 10; p_idle = 30;  end
         2:       begin p_req = 100; p_rd = 5;  p_idle = 100; end
         default: begin p_req = 30;  p_rd = 50; p_idle = 70;  end
      endcase
      rst       = (cyc < 2) || (cyc % 400 == 399);
      req_valid = ($urandom_range(0, 99) < p_req);
      req_rw    = ($urandom_range(0, 99) < p_rd);
      req_sz    = 1'($urandom);
      req_a0    = 1'($urandom);
      req_addr  = AW'($urandom);
      req_wdata = 16'($urandom);
      eng_idle  = ($urandom_range(0, 99) < p_idle);
      eng_rdata = 16'($urandom);
      eng_done  = 1'b0;
      if (eng_cnt > 0) begin
         eng_cnt--;
         if (eng_cnt == 0) eng_done = 1'b1;
      end else if ($urandom_range(0, 15) == 0) begin
         eng_done = 1'b1;
      end
      f_push  = ($urandom_range(0, 99) < (cyc[0] ? 40 : 65));
      f_pop   = ($urandom_range(0, 99) < 50);
      f_wdata = {9'($urandom), $urandom};
   endtask

   task automatic sample_cycle();
      bit  exp_ready, work, do_launch;
      op_t req_op;
      exp_ready = !rst && !m_pend && ((req_rw == RD) || !WbufEn || (wq.size() < DEPTH));
      check_eq("req_ready", 64'(req_ready), 64'(exp_ready));
      check_eq("wbuf_level", 64'(wbuf_level), WbufEn ? 64'(wq.size()) : 64'd0);
      check_eq("txn_in_progress", 64'(txn_in_progress),
               64'((wq.size() != 0) || m_pend || start_due || outstanding));
      check_eq("rd_valid", 64'(rd_valid), 64'(m_rdv));
      check_eq("rd_data", 64'(rd_data), 64'(m_rdd));
      check_eq("eng_start", 64'(eng_start), 64'(start_due));
      check_eq("eng_rw", 64'(eng_rw), 64'(last_op.rw));
      check_eq("eng_sz", 64'(eng_sz), 64'(last_op.sz));
      check_eq("eng_a0", 64'(eng_a0), 64'(last_op.a0));
      check_eq("eng_addr", 64'(eng_addr), 64'(last_op.addr));
      if (last_op.rw == WR) check_eq("eng_wdata", 64'(eng_wdata), 64'(last_op.wdata));

      check_eq("fifo_level", 64'(f_level), 64'(fq.size()));
      check_eq("fifo_full", 64'(f_full), 64'(fq.size() == DEPTH));
      check_eq("fifo_empty", 64'(f_empty), 64'(fq.size() == 0));
      if (fq.size() != 0) check_eq("fifo_head", 64'(f_rdata), 64'(fq[0]));

      if (eng_start) eng_cnt = $urandom_range(1, 5);

      if (rst) begin
         model_reset();
      end else begin
         work      = (WbufEn && (wq.size() != 0)) || m_pend;
         do_launch = !start_due && !outstanding && work && eng_idle;
         if (start_due) begin
            start_due   = 1'b0;
            outstanding = 1'b1;
         end else if (outstanding && eng_done) begin
            outstanding = 1'b0;
            if (WbufEn && (cur_op.rw == WR)) begin
               void'(wq.pop_front());
            end else begin
               m_pend = 1'b0;
               if (cur_op.rw == RD) begin
                  m_rdv = 1'b1;
                  m_rdd = eng_rdata;
               end
            end
         end
         if (do_launch) begin
            cur_op    = (WbufEn && (wq.size() != 0)) ? wq[0] : pend_op;
            last_op   = cur_op;
            start_due = 1'b1;
         end
         if (req_valid && exp_ready) begin
            m_rdv  = 1'b0;
            req_op = '{rw: req_rw, sz: req_sz, a0: req_a0, addr: req_addr, wdata: req_wdata};
            if (WbufEn && (req_rw == WR)) begin
               wq.push_back(req_op);
            end else begin
               m_pend  = 1'b1;
               pend_op = req_op;
            end
         end

         if (f_pop && (fq.size() != 0)) void'(fq.pop_front());
         if (f_push && (fq.size() < DEPTH)) fq.push_back(f_wdata);
      end
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = 1'b0;
      req_rw    = RD;
      req_sz    = 1'b0;
      req_a0    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      eng_idle  = 1'b0;
      eng_done  = 1'b0;
      eng_rdata = '0;
      f_push    = 1'b0;
      f_pop     = 1'b0;
      f_wdata   = '0;
      model_reset();
      @(posedge c7m);
      #1;
      for (int cyc = 0; cyc < NCYC; cyc++) begin
         drive_cycle(cyc);
         @(negedge c7m);
         if (cyc == 0) check_eq("eng_wdata_rst", 64'(eng_wdata), 64'd0);
         sample_cycle();
         @(posedge c7m);
         #1;
      end
      $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
      $finish;
   end

endmodule
